// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one trial subtraction and one quotient bit per clock, MSB first.
// Optional two's-complement operation is enabled by defining SIGNED_DIV_EN.
module seq_divider #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST_C  = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  ZERO_W  = {W{1'b0}};
  localparam logic [W-1:0]  ONES_W  = {W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [W-1:0]  rem_r;
  logic [W-1:0]  q_r;
  logic [W-1:0]  den_r;
  logic [CW-1:0] cnt_r;
  logic [W:0]    trial_s;
  logic          borrow_s;
  logic [W-1:0]  rem_nxt_s;
  logic [W-1:0]  q_nxt_s;
  logic          accept_s;
  logic          zero_div_s;
  logic          last_iter_s;
  logic [W-1:0]  dvd_mag_s;
  logic [W-1:0]  dvs_mag_s;
  logic [W-1:0]  quo_fix_s;
  logic [W-1:0]  rem_fix_s;

  // Trial subtraction; the top bit of the (W+1)-bit difference is the borrow.
  always_comb begin
    trial_s  = {rem_r, q_r[W-1]} - {1'b0, den_r};
    borrow_s = trial_s[W];
    if (borrow_s) begin
      rem_nxt_s = {rem_r[W-2:0], q_r[W-1]};
    end else begin
      rem_nxt_s = trial_s[W-1:0];
    end
    q_nxt_s = {q_r[W-2:0], ~borrow_s};
  end

  // Next-state decode and transition strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    zero_div_s  = 1'b0;
    last_iter_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          if (divisor == ZERO_W) begin
            zero_div_s  = 1'b1;
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = CALC;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == LAST_C) begin
          last_iter_s = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CALC;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

`ifdef SIGNED_DIV_EN
  logic neg_q_r;
  logic neg_r_r;

  function automatic logic [W-1:0] negate(input logic [W-1:0] v);
    negate = ~v + {{(W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
    if (v[W-1]) begin
      magnitude = negate(v);
    end else begin
      magnitude = v;
    end
  endfunction

  // Unsigned engine sees magnitudes; signs are reapplied as the result is registered.
  always_comb begin
    dvd_mag_s = magnitude(dividend);
    dvs_mag_s = magnitude(divisor);
    if (neg_q_r) begin
      quo_fix_s = negate(q_nxt_s);
    end else begin
      quo_fix_s = q_nxt_s;
    end
    if (neg_r_r) begin
      rem_fix_s = negate(rem_nxt_s);
    end else begin
      rem_fix_s = rem_nxt_s;
    end
  end

  // Operand sign capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (accept_s && !zero_div_s) begin
      neg_q_r <= dividend[W-1] ^ divisor[W-1];
      neg_r_r <= dividend[W-1];
    end
  end
`else
  // Unsigned build: operands and results pass straight through.
  always_comb begin
    dvd_mag_s = dividend;
    dvs_mag_s = divisor;
    quo_fix_s = q_nxt_s;
    rem_fix_s = rem_nxt_s;
  end
`endif

  // Datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r       <= ZERO_W;
      q_r         <= ZERO_W;
      den_r       <= ZERO_W;
      cnt_r       <= {CW{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= ZERO_W;
      remainder   <= ZERO_W;
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (accept_s) begin
            busy <= 1'b1;
            if (zero_div_s) begin
              done        <= 1'b1;
              quotient    <= ONES_W;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              rem_r       <= ZERO_W;
              q_r         <= dvd_mag_s;
              den_r       <= dvs_mag_s;
              cnt_r       <= {CW{1'b0}};
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          rem_r <= rem_nxt_s;
          q_r   <= q_nxt_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (last_iter_s) begin
            done      <= 1'b1;
            quotient  <= quo_fix_s;
            remainder <= rem_fix_s;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed scoreboard bench for seq_divider (W=8); expected results come from a behavioural model.
module tb_seq_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  seq_divider #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Busy-cycle and done-pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t m;
    int   qi;
    int   ri;
    if (b == 8'd0) begin
      m.q = 8'hFF; m.r = a; m.dbz = 1'b1;
    end else begin
`ifdef SIGNED_DIV_EN
      qi = int'($signed(a)) / int'($signed(b));
      ri = int'($signed(a)) % int'($signed(b));
`else
      qi = int'(a) / int'(b);
      ri = int'(a) % int'(b);
`endif
      m.q = 8'(qi); m.r = 8'(ri); m.dbz = 1'b0;
    end
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit push);
    dividend = a; divisor = b; start = 1'b1;
    if (push) sb.push_back(model(a, b));
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit got);
    lat = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!got) begin
        @(negedge clk);
        if (done === 1'b1) got = 1'b1;
        else lat++;
      end
    end
  endtask

  // Waits for done, compares latency and popped scoreboard entry, then moves to the next cycle.
  task automatic finish_op(input string tag, input int exp_lat);
    int   lat;
    bit   got;
    exp_t e;
    wait_done(lat, got);
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_quotient"}, 32'(quotient), 32'(e.q));
      check({tag, "_remainder"}, 32'(remainder), 32'(e.r));
      check({tag, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
    end
    step();
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string tag);
    issue(a, b, 1'b1);
    finish_op(tag, (b == 8'd0) ? 0 : 8);
  endtask

  initial begin
    int b0;
    int d0;
    logic [7:0] ra;
    logic [7:0] rb;
    rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // 100/7: constants from the plan plus busy/done counts
    b0 = busy_cnt; d0 = done_cnt;
    run_op(8'd100, 8'd7, "d100_7");
    check("d100_7_q_const", 32'(quotient), 32'd14);
    check("d100_7_r_const", 32'(remainder), 32'd2);
    check("d100_7_busy_cycles", 32'(busy_cnt - b0), 32'd9);
    check("d100_7_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Divide by zero then a clearing divide by one
    b0 = busy_cnt;
    run_op(8'd5, 8'd0, "d5_0");
    check("d5_0_q_const", 32'(quotient), 32'hFF);
    check("d5_0_busy_cycles", 32'(busy_cnt - b0), 32'd1);
    run_op(8'd255, 8'd1, "d255_1");
    check("d255_1_dbz_clear", 32'(div_by_zero), 32'd0);

    // Back-to-back: second start in the cycle after done
    d0 = done_cnt;
    run_op(8'd3, 8'd10, "d3_10");
    run_op(8'd0, 8'd9, "d0_9");
    check("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);

    // Ignored start with changed operands mid-calculation
    d0 = done_cnt;
    issue(8'd200, 8'd3, 1'b1);
    step(); step(); step();
    dividend = 8'd50; divisor = 8'd5; start = 1'b1;
    step();
    start = 1'b0;
    finish_op("d200_3_intr", 4);
    check("d200_3_q_const", 32'(quotient), 32'd66);
    repeat (12) step();
    check("intr_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("intr_idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-division
    issue(8'd200, 8'd3, 1'b0);
    step(); step(); step(); step();
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_quotient", 32'(quotient), 32'd0);
    check("mid_rst_remainder", 32'(remainder), 32'd0);
    check("mid_rst_dbz", 32'(div_by_zero), 32'd0);
    step();
    rst = 1'b0;
    step();
    run_op(8'd77, 8'd7, "d77_7");

    // Edge operands
    run_op(8'd37, 8'd1, "d37_1");
    run_op(8'd12, 8'd200, "d12_200");
    run_op(8'd255, 8'd255, "d255_255");
    run_op(8'd254, 8'd255, "d254_255");
    run_op(8'd128, 8'd16, "d128_16");
    run_op(8'd0, 8'd0, "d0_0");

`ifdef SIGNED_DIV_EN
    run_op(8'h9C, 8'd7, "s_m100_7");
    check("s_m100_7_q_const", 32'(quotient), 32'hF2);
    check("s_m100_7_r_const", 32'(remainder), 32'hFE);
    run_op(8'h80, 8'hFF, "s_m128_m1");
    check("s_m128_m1_q_const", 32'(quotient), 32'h80);
    run_op(8'd100, 8'hF9, "s_100_m7");
`endif

    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      run_op(ra, rb, "rand");
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
